jts16_vidout: RTL and testbench
===============================

# jts16_vidout

Video output stage placed directly downstream of `jts16_video`. It takes the 5-bit RGB, delayed blanking and raw sync from the colour mixer. It applies a per-frame horizontal picture shift for screen centring, expands colour to 8 bits per gun and forces black during blanking. All outputs are re-registered so the frame reaches the board scaler or OSD with fixed, known alignment.

## Interface
Parameters:
- `BASE_DLY`, 8: nominal pixel delay applied to picture and timing signals; legal range 8..15.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pxl_cen` in 1: pixel clock enable.
- `red`, `green`, `blue` in 5 each: colour from the mixer.
- `LHBL_dly`, `LVBL_dly` in 1: active-high video-active flags from the mixer.
- `HS`, `VS` in 1: syncs from the timer.
- `hshift` in 4: signed picture shift, −8..+7 pixels; positive moves the picture right.
- `sl_en` in 1: scanline dimming request (only used under the macro).
- `r8`, `g8`, `b8` out 8 each: expanded colour.
- `LHBL_out`, `LVBL_out`, `HS_out`, `VS_out` out 1: aligned timing signals.
- `de` out 1: `LHBL_out & LVBL_out`.

## Operation
- **Ring buffer:** 16 × 15-bit pixel registers with a 4-bit write pointer `wp`. On each `pxl_cen`, `{red,green,blue}` is written at `wp` and then `wp` is incremented; it wraps 15→0.
- **Read pointer:** `rp = wp − (BASE_DLY + hs_lat)`, computed modulo 16. Picture delay is `BASE_DLY + hs_lat`, with range 0..15 pixels at the default.
- **Shift latch:** `hs_lat` captures `hshift` on the `pxl_cen` at which a rising edge of `VS` is detected. A mid-frame change to `hshift` has no effect until the next frame. The sum `BASE_DLY + hs_lat` is clamped to 0..15. Reset value of `hs_lat` is 0.
- **Timing delay:** `LHBL_dly`, `LVBL_dly`, `HS` and `VS` pass through a fixed shift register `BASE_DLY` deep, advanced on `pxl_cen`. Timing signals are never affected by `hshift`.
- **Colour expansion:** each gun `c` becomes `{c, c[4:2]}`, so 0→0x00 and 31→0xFF.
- **Blanking:** when the delayed `LHBL` or `LVBL` is 0, `r8`, `g8` and `b8` are 0x00. Pixels shifted into the blank window are discarded.
- **Output register:** all outputs are registered on `clk` when `pxl_cen` is high.
- **Reset:** every output is 0 and the ring and all delay stages are cleared. The first frame after reset therefore shows black until the data and delay pipes fill.

## Timing
- **Timing latency:** input timing sampled at `pxl_cen` tick k appears on the outputs at tick k + `BASE_DLY`.
- **Colour latency:** input colour at tick k appears at tick k + `BASE_DLY` + `hs_lat`.
- **Output update:** outputs change only in the `clk` cycle after a `pxl_cen`-qualified edge. They hold between enables.
- **`de` equality:** `de` is exactly `LHBL_out & LVBL_out` on every cycle.
- **Simultaneous events:** if a `VS` rise and an `hshift` change occur on the same tick, the new value is latched.
- **Reset mid-line:** outputs drop to 0 asynchronously. Normal alignment resumes `BASE_DLY` ticks after release.

## Configuration
- **`JTS16_VIDOUT_SCANLINE_EN` defined:**
  - A line-parity bit toggles on each falling edge of the delayed `LHBL` and is cleared on the rising edge of the delayed `VS`.
  - When `sl_en` = 1 and parity = 1, each expanded gun `e` is output as `e − (e>>2)`, i.e. 75 %.
- **Macro undefined:** the parity logic is absent, `sl_en` is ignored, and colour is always full intensity.

## Structure
- **Shared package `jts16_vidout_pkg`:**
  - `RING_DEPTH = 16`
  - `PXL_W = 15`
  - typedef `pxl15_t`
  - function `expand5to8`
- **Sub-module `jts16_vidout_dly`:** generic `pxl_cen`-gated shift register (parameters: width, depth), used for the timing path.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs 0. Release and feed a constant red = 31 active frame → after 8 ticks `r8` = 0xFF and `g8` = `b8` = 0.
- **Zero shift:** `hshift` = 0, inject one pixel of green = 16 at the first active tick → `g8` = 0x84 exactly 8 ticks later, coincident with the first active `LHBL_out` tick.
- **Positive shift:** `hshift` = +3 latched at `VS` → the same pixel appears 11 ticks after input, while the timing signals stay at 8 ticks.
- **Mid-frame change:** change `hshift` from 0 to −4 mid-frame → the current frame is unchanged; the next frame has colour delay 4. Check that the first 4 ticks of blank-to-active are black, not stale data.
- **Clamp:** `BASE_DLY` = 15 with `hshift` = +7 → delay clamps to 15.
- **Scanlines:** with the macro defined and `sl_en` = 1, full white (31,31,31) → even lines output 0xFF and odd lines 0xC0. Without the macro, all lines output 0xFF.

Source files
------------

// File: rtl/jts16_vidout_pkg.sv
// Shared types and colour helpers for the jts16_vidout output stage.
package jts16_vidout_pkg;

   localparam int RING_DEPTH = 16;
   localparam int PXL_W      = 15;

   typedef logic [PXL_W-1:0] pxl15_t;
   typedef logic [3:0]       ring_ptr_t;

   typedef struct packed {
      logic lhbl;
      logic lvbl;
      logic hs;
      logic vs;
   } vtiming_t;

   function automatic logic [7:0] expand5to8(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   // Scanline dimming keeps 75 % of the expanded gun
   function automatic logic [7:0] shade(input logic [4:0] c, input logic dim);
      logic [7:0] e;
      e = expand5to8(c);
      return dim ? (e - {2'b00, e[7:2]}) : e;
   endfunction

endpackage

// File: rtl/jts16_vidout_dly.sv
// Generic pixel-enable gated shift register used to align the timing signals.
module jts16_vidout_dly #(
   parameter int W     = 4,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cen,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (cen) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/jts16_vidout.sv
// Video output stage: per-frame horizontal shift, 5->8 bit expansion, blanking.
// Optional scanline dimming is built when JTS16_VIDOUT_SCANLINE_EN is defined.
module jts16_vidout
   import jts16_vidout_pkg::*;
#(
   parameter int BASE_DLY = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pxl_cen,
   input  logic [4:0] red,
   input  logic [4:0] green,
   input  logic [4:0] blue,
   input  logic       LHBL_dly,
   input  logic       LVBL_dly,
   input  logic       HS,
   input  logic       VS,
   input  logic [3:0] hshift,
   input  logic       sl_en,
   output logic [7:0] r8,
   output logic [7:0] g8,
   output logic [7:0] b8,
   output logic       LHBL_out,
   output logic       LVBL_out,
   output logic       HS_out,
   output logic       VS_out,
   output logic       de
);

   pxl15_t           ring [RING_DEPTH];
   ring_ptr_t        wp;
   ring_ptr_t        rp;
   ring_ptr_t        dly;
   logic [3:0]       hs_lat;
   logic             vs_last;
   logic signed [5:0] dly_sum;
   pxl15_t           pix_in;
   pxl15_t           pix_rd;
   vtiming_t         tin;
   vtiming_t         tdl;
   logic             dim;
   logic             active;

   assign pix_in = {red, green, blue};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         for (int i = 0; i < RING_DEPTH; i++) ring[i] <= '0;
      end else if (pxl_cen) begin
         ring[wp] <= pix_in;
         wp       <= wp + 4'd1;
      end
   end

   // The shift is only sampled at the start of a frame so the picture never tears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_lat  <= '0;
         vs_last <= 1'b0;
      end else if (pxl_cen) begin
         vs_last <= VS;
         if (VS && !vs_last) hs_lat <= hshift;
      end
   end

   assign dly_sum = 6'(BASE_DLY) + {{2{hs_lat[3]}}, hs_lat};

   always_comb begin
      dly = 4'd0;
      if (dly_sum > 6'sd15) dly = 4'd15;
      else if (dly_sum >= 6'sd0) dly = dly_sum[3:0];
   end

   // A zero delay would read the slot being written this edge, so bypass it
   assign rp     = wp - dly;
   assign pix_rd = (dly == 4'd0) ? pix_in : ring[rp];

   assign tin.lhbl = LHBL_dly;
   assign tin.lvbl = LVBL_dly;
   assign tin.hs   = HS;
   assign tin.vs   = VS;

   jts16_vidout_dly #(
      .W     ($bits(vtiming_t)),
      .DEPTH (BASE_DLY)
   ) u_tdly (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (pxl_cen),
      .din   (tin),
      .dout  (tdl)
   );

   assign active = tdl.lhbl & tdl.lvbl;

`ifdef JTS16_VIDOUT_SCANLINE_EN
   logic parity;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
      end else if (pxl_cen) begin
         if (tdl.vs && !VS_out) parity <= 1'b0;
         else if (!tdl.lhbl && LHBL_out) parity <= ~parity;
      end
   end

   assign dim = sl_en & parity;
`else
   logic unused_sl;
   assign unused_sl = sl_en;
   assign dim       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r8       <= '0;
         g8       <= '0;
         b8       <= '0;
         LHBL_out <= 1'b0;
         LVBL_out <= 1'b0;
         HS_out   <= 1'b0;
         VS_out   <= 1'b0;
         de       <= 1'b0;
      end else if (pxl_cen) begin
         r8       <= active ? shade(pix_rd[14:10], dim) : 8'd0;
         g8       <= active ? shade(pix_rd[9:5], dim)   : 8'd0;
         b8       <= active ? shade(pix_rd[4:0], dim)   : 8'd0;
         LHBL_out <= tdl.lhbl;
         LVBL_out <= tdl.lvbl;
         HS_out   <= tdl.hs;
         VS_out   <= tdl.vs;
         de       <= active;
      end
   end

endmodule

// File: tb/tb_jts16_vidout.sv
// Directed bench for jts16_vidout: latency, frame-latched shift, clamping, blanking, reset.
module tb_jts16_vidout;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pxl_cen = 1'b0;
   logic [4:0] red = '0, green = '0, blue = '0;
   logic       LHBL_dly = 1'b0, LVBL_dly = 1'b0, HS = 1'b0, VS = 1'b0;
   logic [3:0] hshift = '0;
   logic       sl_en = 1'b0;

   logic [7:0] r8, g8, b8, r8_2, g8_2, b8_2;
   logic       LHBL_out, LVBL_out, HS_out, VS_out, de;
   logic       LHBL_out2, LVBL_out2, HS_out2, VS_out2, de2;

   int n_tests = 0;
   int n_fail  = 0;
   int tick    = 0;
   int blank_t = 0;

   logic [7:0] obs_r [0:2047];
   logic [7:0] obs_g [0:2047];
   logic [7:0] obs_b [0:2047];
   logic       obs_lh [0:2047];
   logic       obs_lv [0:2047];
   logic       obs_hs [0:2047];
   logic       obs_vs [0:2047];
   logic       obs_de [0:2047];
   logic [7:0] obs2_g [0:2047];
   logic       obs2_lh [0:2047];

   localparam logic [14:0] G16   = {5'd0, 5'd16, 5'd0};
   localparam logic [14:0] B31   = {5'd0, 5'd0, 5'd31};
   localparam logic [14:0] R31   = {5'd31, 5'd0, 5'd0};
   localparam logic [14:0] WHITE = {5'd31, 5'd31, 5'd31};
`ifdef JTS16_VIDOUT_SCANLINE_EN
   localparam logic [7:0] ODD_EXP = 8'hC0;
`else
   localparam logic [7:0] ODD_EXP = 8'hFF;
`endif

   always #5 clk = ~clk;

   jts16_vidout #(.BASE_DLY(8)) dut (
      .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
      .red(red), .green(green), .blue(blue),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .HS(HS), .VS(VS),
      .hshift(hshift), .sl_en(sl_en),
      .r8(r8), .g8(g8), .b8(b8),
      .LHBL_out(LHBL_out), .LVBL_out(LVBL_out), .HS_out(HS_out), .VS_out(VS_out),
      .de(de)
   );

   jts16_vidout #(.BASE_DLY(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
      .red(red), .green(green), .blue(blue),
      .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .HS(HS), .VS(VS),
      .hshift(hshift), .sl_en(sl_en),
      .r8(r8_2), .g8(g8_2), .b8(b8_2),
      .LHBL_out(LHBL_out2), .LVBL_out(LVBL_out2), .HS_out(HS_out2), .VS_out(VS_out2),
      .de(de2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // One pixel tick: enable high for one clk, low for the next; outputs recorded per tick
   task automatic applyStimulus(input logic [14:0] pix, input logic lh, input logic lv,
                                input logic hs_i, input logic vs_i, input logic [3:0] sh);
      @(negedge clk);
      {red, green, blue} = pix;
      LHBL_dly = lh;
      LVBL_dly = lv;
      HS       = hs_i;
      VS       = vs_i;
      hshift   = sh;
      pxl_cen  = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      obs_r[tick]   = r8;
      obs_g[tick]   = g8;
      obs_b[tick]   = b8;
      obs_lh[tick]  = LHBL_out;
      obs_lv[tick]  = LVBL_out;
      obs_hs[tick]  = HS_out;
      obs_vs[tick]  = VS_out;
      obs_de[tick]  = de;
      obs2_g[tick]  = g8_2;
      obs2_lh[tick] = LHBL_out2;
      tick++;
   endtask

   task automatic blankLine(input logic lv, input logic vs_pulse, input logic [3:0] sh);
      blank_t = tick;
      for (int i = 0; i < 10; i++)
         applyStimulus(15'd0, 1'b0, lv, (i == 1), vs_pulse && (i == 2), sh);
   endtask

   task automatic activeRun(input int n, input logic [14:0] pix, input logic [3:0] sh);
      for (int i = 0; i < n; i++) applyStimulus(pix, 1'b1, 1'b1, 1'b0, 1'b0, sh);
   endtask

   task automatic redFrame(input string tag);
      tick = 0;
      activeRun(12, R31, 4'd0);
      checkOutput({tag, "_r_t7"},  {24'd0, obs_r[7]}, 32'h00);
      checkOutput({tag, "_lh_t7"}, {31'd0, obs_lh[7]}, 32'd0);
      checkOutput({tag, "_r_t8"},  {24'd0, obs_r[8]}, 32'hFF);
      checkOutput({tag, "_gb_t8"}, {16'd0, obs_g[8], obs_b[8]}, 32'h0000);
      checkOutput({tag, "_de_t8"}, {31'd0, obs_de[8]}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int a, a0, a1, vb_t, hs_t, vs_t;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;

      // Inputs toggling under reset must not reach the outputs
      applyStimulus(WHITE, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
      applyStimulus(WHITE, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      applyStimulus(WHITE, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
      checkOutput("rst_rgb", {8'd0, r8, g8, b8}, 32'd0);
      checkOutput("rst_tim", {27'd0, LHBL_out, LVBL_out, HS_out, VS_out, de}, 32'd0);
      checkOutput("rst_dut15", {3'd0, r8_2, g8_2, b8_2, LHBL_out2, LVBL_out2, HS_out2, VS_out2, de2},
                  32'd0);
      applyStimulus(15'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      redFrame("rel1");

      // Horizontal-active but vertical-blank pixels must stay black with de low
      vb_t = tick;
      for (int i = 0; i < 3; i++) applyStimulus(WHITE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      blankLine(1'b0, 1'b1, 4'd0);
      hs_t = blank_t + 1;
      vs_t = blank_t + 2;
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      activeRun(11, 15'd0, 4'd0);
      checkOutput("vb_lh",  {31'd0, obs_lh[vb_t+8]}, 32'd1);
      checkOutput("vb_lv",  {31'd0, obs_lv[vb_t+8]}, 32'd0);
      checkOutput("vb_de",  {31'd0, obs_de[vb_t+8]}, 32'd0);
      checkOutput("vb_r",   {24'd0, obs_r[vb_t+8]}, 32'h00);
      checkOutput("hs_t7",  {31'd0, obs_hs[hs_t+7]}, 32'd0);
      checkOutput("hs_t8",  {31'd0, obs_hs[hs_t+8]}, 32'd1);
      checkOutput("vs_t8",  {31'd0, obs_vs[vs_t+8]}, 32'd1);
      checkOutput("vs_t9",  {31'd0, obs_vs[vs_t+9]}, 32'd0);
      checkOutput("z_g_t7", {24'd0, obs_g[a+7]}, 32'h00);
      checkOutput("z_lh_t7",{31'd0, obs_lh[a+7]}, 32'd0);
      checkOutput("z_g_t8", {24'd0, obs_g[a+8]}, 32'h84);
      checkOutput("z_de_t8",{31'd0, obs_de[a+8]}, 32'd1);
      checkOutput("z_g_t9", {24'd0, obs_g[a+9]}, 32'h00);

      // Shift +3: colour at 11 ticks, timing still at 8
      blankLine(1'b1, 1'b1, 4'd3);
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
      activeRun(11, 15'd0, 4'd3);
      checkOutput("p3_lh_t7", {31'd0, obs_lh[a+7]}, 32'd0);
      checkOutput("p3_lh_t8", {31'd0, obs_lh[a+8]}, 32'd1);
      checkOutput("p3_g_t8",  {24'd0, obs_g[a+8]}, 32'h00);
      checkOutput("p3_g_t10", {24'd0, obs_g[a+10]}, 32'h00);
      checkOutput("p3_g_t11", {24'd0, obs_g[a+11]}, 32'h84);

      // Mid-frame change to -4 has no effect until the next VS
      blankLine(1'b1, 1'b1, 4'd0);
      activeRun(5, 15'd0, 4'd0);
      activeRun(2, 15'd0, 4'hC);
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
      activeRun(9, 15'd0, 4'hC);
      checkOutput("mid_g_t4", {24'd0, obs_g[a+4]}, 32'h00);
      checkOutput("mid_g_t8", {24'd0, obs_g[a+8]}, 32'h84);

      blankLine(1'b1, 1'b1, 4'hC);
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
      activeRun(3, 15'd0, 4'hC);
      applyStimulus(B31, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
      activeRun(1, 15'd0, 4'hC);
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
      activeRun(8, 15'd0, 4'hC);
      checkOutput("m4_lh_t4",  {31'd0, obs_lh[a+4]}, 32'd0);
      checkOutput("m4_g_t4",   {24'd0, obs_g[a+4]}, 32'h00);
      checkOutput("m4_g_t8",   {24'd0, obs_g[a+8]}, 32'h00);
      checkOutput("m4_b_t8",   {24'd0, obs_b[a+8]}, 32'hFF);
      checkOutput("m4_b_t9",   {24'd0, obs_b[a+9]}, 32'h00);
      checkOutput("m4_g_t10",  {24'd0, obs_g[a+10]}, 32'h84);

      // Shift -8: zero delay on BASE 8, delay 7 on BASE 15
      blankLine(1'b1, 1'b1, 4'h8);
      activeRun(9, 15'd0, 4'h8);
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
      activeRun(9, 15'd0, 4'h8);
      checkOutput("lo_g_tm1",  {24'd0, obs_g[a-1]}, 32'h00);
      checkOutput("lo_g_t0",   {24'd0, obs_g[a]}, 32'h84);
      checkOutput("lo_lh_t0",  {31'd0, obs_lh[a]}, 32'd1);
      checkOutput("lo_g_t1",   {24'd0, obs_g[a+1]}, 32'h00);
      checkOutput("lo15_g_t6", {24'd0, obs2_g[a+6]}, 32'h00);
      checkOutput("lo15_g_t7", {24'd0, obs2_g[a+7]}, 32'h84);

      // Shift +7: both instances land on the 15-tick maximum
      blankLine(1'b1, 1'b1, 4'd7);
      a = tick;
      applyStimulus(G16, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7);
      activeRun(17, 15'd0, 4'd7);
      checkOutput("hi_g_t14",    {24'd0, obs_g[a+14]}, 32'h00);
      checkOutput("hi_g_t15",    {24'd0, obs_g[a+15]}, 32'h84);
      checkOutput("hi15_lh_t14", {31'd0, obs2_lh[a+14]}, 32'd0);
      checkOutput("hi15_lh_t15", {31'd0, obs2_lh[a+15]}, 32'd1);
      checkOutput("hi15_g_t14",  {24'd0, obs2_g[a+14]}, 32'h00);
      checkOutput("hi15_g_t15",  {24'd0, obs2_g[a+15]}, 32'h84);
      checkOutput("hi15_g_t16",  {24'd0, obs2_g[a+16]}, 32'h00);

      // Scanlines: line after VS is even, the next one odd
      sl_en = 1'b1;
      blankLine(1'b1, 1'b1, 4'd0);
      a0 = tick;
      activeRun(8, WHITE, 4'd0);
      blankLine(1'b1, 1'b0, 4'd0);
      a1 = tick;
      activeRun(8, WHITE, 4'd0);
      blankLine(1'b1, 1'b0, 4'd0);
      checkOutput("sl_even_r", {24'd0, obs_r[a0+10]}, 32'hFF);
      checkOutput("sl_odd_r",  {24'd0, obs_r[a1+10]}, {24'd0, ODD_EXP});
      checkOutput("sl_odd_b",  {24'd0, obs_b[a1+12]}, {24'd0, ODD_EXP});
      sl_en = 1'b0;

      // Asynchronous reset in the middle of an active line
      activeRun(12, WHITE, 4'd0);
      checkOutput("pre_rst_r", {24'd0, r8}, 32'hFF);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_rgb", {8'd0, r8, g8, b8}, 32'd0);
      checkOutput("arst_tim", {27'd0, LHBL_out, LVBL_out, HS_out, VS_out, de}, 32'd0);
      checkOutput("arst_dut15", {3'd0, r8_2, g8_2, b8_2, LHBL_out2, LVBL_out2, HS_out2, VS_out2, de2},
                  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      redFrame("rel2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
